// File: rtl/mult_div_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op field bits,
// FSM state enum and the default iteration count.
package mult_div_pkg;

    localparam int MD_ITER = 32;

    localparam int OP_DIV_BIT    = 1;
    localparam int OP_SIGNED_BIT = 0;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_t;

endpackage

// File: rtl/mult_div_if.sv
// Operand/result bundle between the register-file side and the multiply/divide
// unit; master drives the request, slave returns the HI/LO result.
interface mult_div_if
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_ITER
);

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, operand_a, operand_b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, operand_a, operand_b,
        output busy, done, div_zero, hi, lo
    );

endinterface

// File: rtl/mult_div_sign_fix.sv
// Sign correction for signed MULT/DIV; only instantiated when MULTDIV_SIGNED_EN
// is defined. Operates on the magnitude result held in the {hi, lo} accumulator.
module mult_div_sign_fix
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_ITER
) (
    input  logic               is_div,
    input  logic               sign_a,
    input  logic               sign_b,
    input  logic [2*WIDTH-1:0] raw,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    // Quotient and product follow the XOR of signs; remainder follows the dividend.
    always_comb begin
        prod = (sign_a ^ sign_b) ? -raw : raw;
        quo  = (sign_a ^ sign_b) ? -raw[WIDTH-1:0] : raw[WIDTH-1:0];
        rem  = sign_a ? -raw[2*WIDTH-1:WIDTH] : raw[2*WIDTH-1:WIDTH];
        if (is_div) begin
            hi = rem;
            lo = quo;
        end else begin
            hi = prod[2*WIDTH-1:WIDTH];
            lo = prod[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider producing MIPS HI/LO.
// Define MULTDIV_SIGNED_EN to honour op[0] (signed MULT/DIV); otherwise all ops are unsigned.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_ITER
) (
    input  logic      clock,
    input  logic      reset_n,
    mult_div_if.slave bus
);

    localparam int            CW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] COUNT_LOAD = CW'(WIDTH - 1);

    md_state_t          state;
    md_state_t          state_next;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   raw_a;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_cand;
    logic [WIDTH-1:0]   div_diff;
    logic               is_div;
    logic               div_zero_reg;
    logic               accept;
    logic               start_is_div;

    assign accept       = bus.start && ((state == IDLE) || (state == DONE));
    assign start_is_div = (bus.op[OP_DIV_BIT] == OP_DIV);

`ifdef MULTDIV_SIGNED_EN
    logic sign_a;
    logic sign_b;
    logic a_neg;
    logic b_neg;

    assign a_neg = bus.op[OP_SIGNED_BIT] && bus.operand_a[WIDTH-1];
    assign b_neg = bus.op[OP_SIGNED_BIT] && bus.operand_b[WIDTH-1];
    assign a_mag = a_neg ? -bus.operand_a : bus.operand_a;
    assign b_mag = b_neg ? -bus.operand_b : bus.operand_b;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sign_a <= 1'b0;
            sign_b <= 1'b0;
        end else if (accept) begin
            sign_a <= a_neg;
            sign_b <= b_neg;
        end
    end

    mult_div_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .is_div (is_div),
        .sign_a (sign_a),
        .sign_b (sign_b),
        .raw    (acc),
        .hi     (fix_hi),
        .lo     (fix_lo)
    );
`else
    logic unused_op_signed;

    assign unused_op_signed = bus.op[OP_SIGNED_BIT];
    assign a_mag  = bus.operand_a;
    assign b_mag  = bus.operand_b;
    assign fix_hi = acc[2*WIDTH-1:WIDTH];
    assign fix_lo = acc[WIDTH-1:0];
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                bus.busy = 1'b1;
                if (count == '0) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                bus.busy   = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = bus.start ? CALC : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The accumulator is {upper, lower}: multiply keeps the multiplier in the
    // lower half and shifts right; divide keeps the dividend/quotient there and
    // shifts left, with the partial remainder in the upper half.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        div_cand = acc[2*WIDTH-1:WIDTH-1];
        div_diff = div_cand[WIDTH-1:0] - addend;
        if (!is_div) begin
            if (acc[0]) begin
                acc_step = {mul_sum, acc[WIDTH-1:1]};
            end else begin
                acc_step = {1'b0, acc[2*WIDTH-1:1]};
            end
        end else if (div_cand >= {1'b0, addend}) begin
            acc_step = {div_diff, acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {div_cand[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    // Divide by zero bypasses sign correction and returns the original dividend.
    always_comb begin
        res_hi = fix_hi;
        res_lo = fix_lo;
        if (is_div && (addend == '0)) begin
            res_hi = raw_a;
            res_lo = '1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count        <= '0;
            acc          <= '0;
            addend       <= '0;
            raw_a        <= '0;
            is_div       <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            div_zero_reg <= 1'b0;
        end else begin
            div_zero_reg <= 1'b0;
            if (accept) begin
                is_div <= start_is_div;
                raw_a  <= bus.operand_a;
                count  <= COUNT_LOAD;
                if (start_is_div) begin
                    acc    <= {{WIDTH{1'b0}}, a_mag};
                    addend <= b_mag;
                end else begin
                    acc    <= {{WIDTH{1'b0}}, b_mag};
                    addend <= a_mag;
                end
            end else if (state == CALC) begin
                acc <= acc_step;
                if (count != '0) begin
                    count <= count - CW'(1);
                end
            end else if (state == FIX) begin
                hi_reg       <= res_hi;
                lo_reg       <= res_lo;
                div_zero_reg <= is_div && (addend == '0);
            end
        end
    end

    assign bus.hi       = hi_reg;
    assign bus.lo       = lo_reg;
    assign bus.div_zero = div_zero_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed scoreboard bench for mult_div_unit; signed cases are exercised only
// when MULTDIV_SIGNED_EN is defined, otherwise op[0] is checked to be ignored.
module tb_mult_div_unit;
    import mult_div_pkg::*;

    localparam logic [1:0] MULTU = 2'b00;
    localparam logic [1:0] MULT  = 2'b01;
    localparam logic [1:0] DIVU  = 2'b10;
    localparam logic [1:0] DIV   = 2'b11;
    localparam int         LAT   = 33;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    exp_t        sb_q[$];
    int          checks     = 0;
    int          errors     = 0;
    int          edge_count = 0;
    int          busy_count = 0;
    logic [31:0] last_hi    = '0;
    logic [31:0] last_lo    = '0;
    logic        done_seen;

    mult_div_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step_cycle();
        @(negedge clock);
        edge_count++;
        if (bus.busy) busy_count++;
    endtask

    // Drives one start pulse; operands are scrambled right after the start edge.
    task automatic apply_stimulus(input logic [1:0] op_in, input logic [31:0] a, input logic [31:0] b,
                                  input bit push, input logic [31:0] e_hi, input logic [31:0] e_lo,
                                  input logic e_dz);
        exp_t e;
        if (push) begin
            e.hi = e_hi;
            e.lo = e_lo;
            e.dz = e_dz;
            sb_q.push_back(e);
        end
        bus.op        = op_in;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.start     = 1'b1;
        edge_count    = 0;
        busy_count    = 0;
        step_cycle();
        bus.start     = 1'b0;
        bus.operand_a = $urandom;
        bus.operand_b = $urandom;
        bus.op        = 2'($urandom);
    endtask

    task automatic wait_result(input string tag);
        bit   got = 0;
        exp_t e;
        while (!got && edge_count < 60) begin
            if (bus.done) got = 1;
            else step_cycle();
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: observed no done after %0d cycles, expected done", tag, edge_count);
            if (sb_q.size() > 0) e = sb_q.pop_front();
        end else if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_unexpected: observed done, expected no pending result", tag);
        end else begin
            e = sb_q.pop_front();
            check_output({tag, "_hi"}, bus.hi, e.hi);
            check_output({tag, "_lo"}, bus.lo, e.lo);
            check_output({tag, "_dz"}, 32'(bus.div_zero), 32'(e.dz));
            check_output({tag, "_latency"}, 32'(edge_count - 1), 32'(LAT));
            check_output({tag, "_busy"}, 32'(busy_count), 32'(LAT));
            last_hi = e.hi;
            last_lo = e.lo;
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.op        = MULTU;
        bus.operand_a = '0;
        bus.operand_b = '0;

        repeat (3) @(negedge clock);
        check_output("reset_busy", 32'(bus.busy), 32'd0);
        check_output("reset_done", 32'(bus.done), 32'd0);
        check_output("reset_dz", 32'(bus.div_zero), 32'd0);
        check_output("reset_hi", bus.hi, 32'd0);
        check_output("reset_lo", bus.lo, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        $display("[TB] unsigned multiply / divide");
        apply_stimulus(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        wait_result("multu_max");

        repeat (3) @(negedge clock);
        check_output("hold_hi", bus.hi, last_hi);
        check_output("hold_lo", bus.lo, last_lo);
        check_output("idle_done", 32'(bus.done), 32'd0);

        apply_stimulus(DIVU, 32'd100, 32'd7, 1, 32'd2, 32'd14, 1'b0);
        wait_result("divu_100_7");
        apply_stimulus(DIVU, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF, 1'b1);
        wait_result("divu_by_zero");

`ifdef MULTDIV_SIGNED_EN
        $display("[TB] signed build");
        apply_stimulus(MULT, 32'hFFFF_FFFD, 32'd5, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        wait_result("mult_neg3_5");
        apply_stimulus(DIV, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        wait_result("div_neg7_2");
        apply_stimulus(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000, 32'h8000_0000, 1'b0);
        wait_result("div_overflow");
        apply_stimulus(DIV, 32'hFFFF_FFF7, 32'd0, 1, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1);
        wait_result("div_signed_zero");
`else
        $display("[TB] unsigned build, op[0] ignored");
        apply_stimulus(DIV, 32'hFFFF_FFF9, 32'd2, 1, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0);
        wait_result("div_op11_unsigned");
        apply_stimulus(MULT, 32'hFFFF_FFFD, 32'd5, 1, 32'h0000_0004, 32'hFFFF_FFF1, 1'b0);
        wait_result("mult_op01_unsigned");
`endif

        $display("[TB] start ignored during CALC");
        apply_stimulus(MULTU, 32'd1000, 32'd3, 1, 32'd0, 32'd3000, 1'b0);
        repeat (4) step_cycle();
        check_output("calc_hold_hi", bus.hi, last_hi);
        check_output("calc_hold_lo", bus.lo, last_lo);
        bus.op        = MULTU;
        bus.operand_a = 32'd7;
        bus.operand_b = 32'd7;
        bus.start     = 1'b1;
        step_cycle();
        bus.start     = 1'b0;
        wait_result("ignore_start");

        $display("[TB] back-to-back from DONE");
        repeat (2) @(negedge clock);
        apply_stimulus(DIVU, 32'hFFFF_FFFF, 32'h10, 1, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0);
        wait_result("b2b_first");
        apply_stimulus(MULTU, 32'h1234_5678, 32'h10, 1, 32'h0000_0001, 32'h2345_6780, 1'b0);
        wait_result("b2b_second");

        $display("[TB] reset during CALC");
        apply_stimulus(MULTU, 32'h1234, 32'h10, 0, '0, '0, 1'b0);
        repeat (9) step_cycle();
        reset_n = 1'b0;
        @(negedge clock);
        check_output("abort_busy", 32'(bus.busy), 32'd0);
        check_output("abort_hi", bus.hi, 32'd0);
        check_output("abort_lo", bus.lo, 32'd0);
        check_output("abort_done", 32'(bus.done), 32'd0);
        reset_n   = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.done) done_seen = 1'b1;
        end
        check_output("abort_no_done", 32'(done_seen), 32'd0);

        apply_stimulus(MULTU, 32'd6, 32'd7, 1, 32'd0, 32'd42, 1'b0);
        wait_result("multu_6_7");

        check_output("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
